// File: rtl/mc_maindec_pkg.sv
// Shared multicycle MIPS controller definitions (state codes, opcodes, mux encodings).
// Also used by aludec and the datapath. ADDI_EN adds the ADDIEX/ADDIWB states.
package mc_defs;

    localparam int STATE_W = 4;
    localparam int OP_W    = 6;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
`ifdef ADDI_EN
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
`endif
        S_JEX     = 4'd11
    } state_e;

    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
    } ctrl_t;

endpackage

// File: rtl/mc_maindec_if.sv
// Control bus between the main decoder (master) and the datapath (slave).
interface mc_maindec_if #(
    parameter int OPW = 6,
    parameter int STW = 4
);
    logic [OPW-1:0] op;
    logic           zero;
    logic           pcen;
    logic           irwrite;
    logic           memwrite;
    logic           regwrite;
    logic           iord;
    logic           memtoreg;
    logic           regdst;
    logic           alusrca;
    logic [1:0]     alusrcb;
    logic [1:0]     pcsrc;
    logic [1:0]     aluop;
    logic           illop;
    logic [STW-1:0] state;

    modport master (
        input  op, zero,
        output pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst,
               alusrca, alusrcb, pcsrc, aluop, illop, state
    );

    modport slave (
        output op, zero,
        input  pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst,
               alusrca, alusrcb, pcsrc, aluop, illop, state
    );
endinterface

// File: rtl/mc_maindec_outdec.sv
// Combinational state -> control-word decode for the multicycle main controller.
// Without ADDI_EN, codes 9/10 fall into the all-zero unreachable decode.
module mc_outdec
    import mc_defs::*;
(
    input  state_e state_i,
    output ctrl_t  ctrl_o
);
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.irwrite = 1'b1;
                ctrl_o.pcwrite = 1'b1;
                ctrl_o.alusrcb = SRCB_FOUR;
            end
            S_DECODE:  ctrl_o.alusrcb = SRCB_IMMSH;
            S_MEMADR: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = SRCB_IMM;
            end
            S_MEMRD:   ctrl_o.iord = 1'b1;
            S_MEMWB: begin
                ctrl_o.regwrite = 1'b1;
                ctrl_o.memtoreg = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.iord     = 1'b1;
                ctrl_o.memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.aluop   = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                ctrl_o.regwrite = 1'b1;
                ctrl_o.regdst   = 1'b1;
            end
            S_BEQEX: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.aluop   = ALUOP_SUB;
                ctrl_o.branch  = 1'b1;
                ctrl_o.pcsrc   = PCSRC_ALUOUT;
            end
`ifdef ADDI_EN
            S_ADDIEX: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = SRCB_IMM;
            end
            S_ADDIWB:  ctrl_o.regwrite = 1'b1;
`endif
            S_JEX: begin
                ctrl_o.pcwrite = 1'b1;
                ctrl_o.pcsrc   = PCSRC_JUMP;
            end
            default:   ctrl_o = '0;
        endcase
    end
endmodule

// File: rtl/mc_maindec.sv
// Multicycle MIPS main controller: state register, next-state logic, pcen and reset gating.
// Define ADDI_EN to support addi (op 001000); otherwise it is treated as illegal.
module mc_maindec
    import mc_defs::*;
#(
    parameter int OPW = 6,
    parameter int STW = 4
)(
    input  logic         clk,
    input  logic         reset,
    mc_maindec_if.master bus
);
    state_e         state_q, state_d;
    ctrl_t          ctrl;
    logic           illegal_op;
    logic [OPW-1:0] op_w;

    assign op_w = bus.op;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // op is only consulted in DECODE and MEMADR; the IR is stable elsewhere.
    always_comb begin
        state_d    = S_FETCH;
        illegal_op = 1'b0;
        case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_DECODE: begin
                case (op_w)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
`ifdef ADDI_EN
                    OP_ADDI:      state_d = S_ADDIEX;
`endif
                    OP_J:         state_d = S_JEX;
                    default:      illegal_op = 1'b1;
                endcase
            end
            S_MEMADR:  state_d = (op_w == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = S_MEMWB;
            S_RTYPEEX: state_d = S_RTYPEWB;
`ifdef ADDI_EN
            S_ADDIEX:  state_d = S_ADDIWB;
`endif
            default:   state_d = S_FETCH;
        endcase
    end

    mc_outdec u_outdec (
        .state_i (state_q),
        .ctrl_o  (ctrl)
    );

    // Reset pulls state to FETCH at once; the write enables are held off until release.
    assign bus.pcen     = ~reset & (ctrl.pcwrite | (ctrl.branch & bus.zero));
    assign bus.irwrite  = ~reset & ctrl.irwrite;
    assign bus.memwrite = ~reset & ctrl.memwrite;
    assign bus.regwrite = ~reset & ctrl.regwrite;
    assign bus.illop    = ~reset & illegal_op;
    assign bus.iord     = ctrl.iord;
    assign bus.memtoreg = ctrl.memtoreg;
    assign bus.regdst   = ctrl.regdst;
    assign bus.alusrca  = ctrl.alusrca;
    assign bus.alusrcb  = ctrl.alusrcb;
    assign bus.pcsrc    = ctrl.pcsrc;
    assign bus.aluop    = ctrl.aluop;
    assign bus.state    = STW'(state_q);
endmodule

// File: tb/tb_mc_maindec.sv
// Directed table-driven bench for mc_maindec, plus a hand sequence for reset during a store.
module tb_mc_maindec;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mc_maindec_if #(.OPW(6), .STW(4)) bus ();
    mc_maindec #(.OPW(6), .STW(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    // {pcen irwrite memwrite regwrite iord memtoreg regdst alusrca | alusrcb | pcsrc | aluop | illop}
    localparam logic [14:0] C_F    = 15'b11000000_01_00_00_0;
    localparam logic [14:0] C_FRST = 15'b00000000_01_00_00_0;
    localparam logic [14:0] C_DEC  = 15'b00000000_11_00_00_0;
    localparam logic [14:0] C_ILL  = 15'b00000000_11_00_00_1;
    localparam logic [14:0] C_MADR = 15'b00000001_10_00_00_0;
    localparam logic [14:0] C_MRD  = 15'b00001000_00_00_00_0;
    localparam logic [14:0] C_MWB  = 15'b00010100_00_00_00_0;
    localparam logic [14:0] C_MWR  = 15'b00101000_00_00_00_0;
    localparam logic [14:0] C_REX  = 15'b00000001_00_00_10_0;
    localparam logic [14:0] C_RWB  = 15'b00010010_00_00_00_0;
    localparam logic [14:0] C_BEQT = 15'b10000001_00_01_01_0;
    localparam logic [14:0] C_BEQF = 15'b00000001_00_01_01_0;
    localparam logic [14:0] C_AEX  = 15'b00000001_10_00_00_0;
    localparam logic [14:0] C_AWB  = 15'b00010000_00_00_00_0;
    localparam logic [14:0] C_JEX  = 15'b10000000_00_10_00_0;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010, BAD = 6'b111111;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        zero;
        logic [3:0]  st;
        logic [14:0] ctl;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add(input logic r, input logic [5:0] o, input logic z,
                       input logic [3:0] s, input logic [14:0] c);
        vec_t v;
        v.rst = r; v.op = o; v.zero = z; v.st = s; v.ctl = c;
        tbl.push_back(v);
    endtask

    function automatic logic [14:0] act_ctl();
        return {bus.pcen, bus.irwrite, bus.memwrite, bus.regwrite, bus.iord,
                bus.memtoreg, bus.regdst, bus.alusrca, bus.alusrcb, bus.pcsrc,
                bus.aluop, bus.illop};
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %b, expected %b", name, idx, act, exp);
        end
    endtask

    task automatic chk_both(input string tag, input int idx, input logic [3:0] s,
                            input logic [14:0] c);
        chk({tag, ".state"}, idx, 32'(bus.state), 32'(s));
        chk({tag, ".ctl"},   idx, 32'(act_ctl()), 32'(c));
    endtask

    initial begin
        bus.op   = LW;
        bus.zero = 1'b0;

        // lw with 3 reset cycles in front
        for (int i = 0; i < 3; i++) add(1, LW, 0, 0, C_FRST);
        add(0, LW, 0, 0, C_F);   add(0, LW, 0, 1, C_DEC);
        add(0, LW, 0, 2, C_MADR); add(0, LW, 0, 3, C_MRD);
        add(0, LW, 0, 4, C_MWB);
        // beq taken then not taken
        add(0, BEQ, 1, 0, C_F);  add(0, BEQ, 1, 1, C_DEC); add(0, BEQ, 1, 8, C_BEQT);
        add(0, BEQ, 0, 0, C_F);  add(0, BEQ, 0, 1, C_DEC); add(0, BEQ, 0, 8, C_BEQF);
        // R-type; op wanders after DECODE and zero is high, neither may matter
        add(0, RT, 1, 0, C_F);   add(0, RT, 1, 1, C_DEC);
        add(0, BAD, 1, 6, C_REX); add(0, LW, 1, 7, C_RWB);
        // illegal opcode: one-cycle illop
        add(0, BAD, 0, 0, C_F);  add(0, BAD, 0, 1, C_ILL);
        add(0, ADDI, 0, 0, C_F);
`ifdef ADDI_EN
        add(0, ADDI, 1, 1, C_DEC); add(0, ADDI, 0, 9, C_AEX); add(0, ADDI, 0, 10, C_AWB);
`else
        add(0, ADDI, 0, 1, C_ILL);
`endif
        // jump
        add(0, J, 0, 0, C_F);    add(0, J, 1, 1, C_DEC); add(0, J, 1, 11, C_JEX);
        add(0, SW, 0, 0, C_F);

        reset = 1'b1;
        foreach (tbl[i]) begin
            @(negedge clk);
            reset    = tbl[i].rst;
            bus.op   = tbl[i].op;
            bus.zero = tbl[i].zero;
            #1;
            chk_both("tbl", i, tbl[i].st, tbl[i].ctl);
        end

        // sw interrupted by an async reset while in MEMWR
        @(negedge clk); #1 chk_both("sw", 0, 4'd1, C_DEC);
        @(negedge clk); #1 chk_both("sw", 1, 4'd2, C_MADR);
        @(negedge clk); #1 chk_both("sw", 2, 4'd5, C_MWR);
        #1 reset = 1'b1;
        #1 chk_both("sw_rst", 3, 4'd0, C_FRST);
        @(negedge clk); #1 chk_both("sw_rst", 4, 4'd0, C_FRST);
        reset = 1'b0;
        #1 chk_both("sw_rel", 5, 4'd0, C_F);
        @(negedge clk); #1 chk_both("sw_rel", 6, 4'd1, C_DEC);
        @(negedge clk); #1 chk_both("sw_rel", 7, 4'd2, C_MADR);
        @(negedge clk); #1 chk_both("sw_rel", 8, 4'd5, C_MWR);
        @(negedge clk); #1 chk_both("sw_rel", 9, 4'd0, C_F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
